// File: rtl/video_timing_pkg.sv
// 720p60 raster constants, RGB888 colour constants and the colour-bar lookup.
// Latency: none (constants and a pure function).
// Backpressure: none; shared by the timing generator and the colour stage.
package video_timing_pkg;

    typedef logic [10:0] pix_coord_t;

    // 720p60 raster, pixel clocks / lines
    localparam pix_coord_t H_SYNC_720P  = 11'd40;
    localparam pix_coord_t H_BACK_720P  = 11'd220;
    localparam pix_coord_t H_DISP_720P  = 11'd1280;
    localparam pix_coord_t H_FRONT_720P = 11'd110;
    localparam pix_coord_t H_TOTAL_720P = 11'd1650;
    localparam pix_coord_t V_SYNC_720P  = 11'd5;
    localparam pix_coord_t V_BACK_720P  = 11'd20;
    localparam pix_coord_t V_DISP_720P  = 11'd720;
    localparam pix_coord_t V_FRONT_720P = 11'd5;
    localparam pix_coord_t V_TOTAL_720P = 11'd750;

    // RGB888 colours
    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    // Colour of bar idx in the 8-bar pattern; anything past bar 6 is black.
    function automatic logic [23:0] bar_colour(input pix_coord_t idx);
        logic [23:0] c;
        case (idx)
            11'd0:   c = RGB_WHITE;
            11'd1:   c = RGB_YELLOW;
            11'd2:   c = RGB_CYAN;
            11'd3:   c = RGB_GREEN;
            11'd4:   c = RGB_MAGENTA;
            11'd5:   c = RGB_RED;
            11'd6:   c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// Wrapping raster axis counter: counts 0..MAX-1 while en is high.
// Latency: cnt moves on the enabled edge; wrap is combinational (en && cnt==MAX-1).
// Backpressure: none; en is a plain count enable, clear a synchronous restart.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter pix_coord_t MAX = H_TOTAL_720P
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clear,
    output logic [10:0] cnt,
    output logic        wrap
);

    assign wrap = en && (cnt == MAX - 11'd1);

    // Count register: async reset, synchronous clear, wrap back to 0 after MAX-1.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || wrap) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 11'd1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// 720p60 raster timing generator; requests pixels one clock early and emits hs/vs/de/rgb.
// Latency: request at t, colour stage registers at t+1, rgb/de out at t+2; hs/vs/de 1 clk after counters.
// Backpressure: none, free-running raster. Optional test pattern (tp_sel) with macro VIDEO_TPG_EN.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter pix_coord_t H_SYNC  = H_SYNC_720P,
    parameter pix_coord_t H_BACK  = H_BACK_720P,
    parameter pix_coord_t H_DISP  = H_DISP_720P,
    parameter pix_coord_t H_FRONT = H_FRONT_720P,
    parameter pix_coord_t V_SYNC  = V_SYNC_720P,
    parameter pix_coord_t V_BACK  = V_BACK_720P,
    parameter pix_coord_t V_DISP  = V_DISP_720P,
    parameter pix_coord_t V_FRONT = V_FRONT_720P,
    parameter logic       HS_POL  = 1'b1,
    parameter logic       VS_POL  = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        sys_rst_n,
`ifdef VIDEO_TPG_EN
    input  logic        tp_sel,
`endif
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        data_req,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [23:0] video_rgb,
    output logic        frame_start
);

    // Totals are derived from the four regions so they can never disagree.
    localparam pix_coord_t H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam pix_coord_t V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam pix_coord_t H_ACT   = H_SYNC + H_BACK;
    localparam pix_coord_t H_END   = H_ACT + H_DISP;
    localparam pix_coord_t V_ACT   = V_SYNC + V_BACK;
    localparam pix_coord_t V_END   = V_ACT + V_DISP;

    pix_coord_t  cnt_h;
    pix_coord_t  cnt_v;
    logic        h_wrap;
    logic        v_wrap;
    logic        origin;
    logic        hs_c;
    logic        vs_c;
    logic        v_act;
    logic        act_c;
    logic [23:0] src_rgb;

    video_axis_counter #(.MAX(H_TOTAL)) u_cnt_h (
        .pixel_clk (pixel_clk),
        .rst_n     (sys_rst_n),
        .en        (1'b1),
        .clear     (1'b0),
        .cnt       (cnt_h),
        .wrap      (h_wrap)
    );

    video_axis_counter #(.MAX(V_TOTAL)) u_cnt_v (
        .pixel_clk (pixel_clk),
        .rst_n     (sys_rst_n),
        .en        (h_wrap),
        .clear     (1'b0),
        .cnt       (cnt_v),
        .wrap      (v_wrap)
    );

    // origin is high exactly while the counters sit at (0,0): set by reset and
    // by the frame wrap, so frame_start needs no 22-bit compare.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            origin <= 1'b1;
        end else begin
            origin <= v_wrap;
        end
    end

    assign hs_c  = cnt_h < H_SYNC;
    assign vs_c  = cnt_v < V_SYNC;
    assign v_act = (cnt_v >= V_ACT) && (cnt_v < V_END);
    assign act_c = v_act && (cnt_h >= H_ACT) && (cnt_h < H_END);

    // Requests run one clock ahead of the active window to cover the colour stage register.
    assign data_req   = v_act && (cnt_h >= H_ACT - 11'd1) && (cnt_h < H_END - 11'd1);
    assign pixel_xpos = data_req ? (cnt_h - (H_ACT - 11'd1)) : 11'd0;
    assign pixel_ypos = v_act ? (cnt_v - V_ACT) : 11'd0;

`ifdef VIDEO_TPG_EN
    localparam pix_coord_t BAR_W = H_DISP >> 3;

    logic        tp_mode;
    logic [23:0] tp_rgb;

    // Pattern select is taken only at the frame origin so a frame is never mixed.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tp_mode <= 1'b0;
        end else if (origin) begin
            tp_mode <= tp_sel;
        end
    end

    // Bar colour registered one clock after the request, like the external colour stage.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tp_rgb <= '0;
        end else begin
            tp_rgb <= bar_colour(pixel_xpos / BAR_W);
        end
    end

    assign src_rgb = tp_mode ? tp_rgb : pixel_data;
`else
    assign src_rgb = pixel_data;
`endif

    // Output stage: every video output comes straight from a flop.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            video_hs    <= ~HS_POL;
            video_vs    <= ~VS_POL;
            video_de    <= 1'b0;
            video_rgb   <= '0;
            frame_start <= 1'b0;
        end else begin
            video_hs    <= hs_c ? HS_POL : ~HS_POL;
            video_vs    <= vs_c ? VS_POL : ~VS_POL;
            video_de    <= act_c;
            video_rgb   <= act_c ? src_rgb : 24'd0;
            frame_start <= origin;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a 720p instance checked against a table of hand-derived points,
// and a shrunken-raster instance checked every cycle against an arithmetic raster model
// with random mid-frame resets, plus whole-frame counts (define VIDEO_TPG_EN for the bar pattern).
module tb_video_timing_gen;

    // Shrunken raster for the small instance
    localparam int HS = 4,  HB = 6, HD = 16, HF = 3;
    localparam int VS = 2,  VB = 3, VD = 6,  VF = 2;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int FR = HT * VT;
    localparam int HA = HS + HB;
    localparam int VA = VS + VB;
    localparam logic HPOL = 1'b0;
    localparam logic VPOL = 1'b1;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic        req;
        logic [10:0] x;
        logic [10:0] y;
        logic [23:0] rgb;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp;
    } vec_t;

    logic        pixel_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic        rst_hd_n  = 1'b0;
    logic        tp_sel    = 1'b0;
    logic        tp_sel_hd = 1'b0;
    logic        mon_en    = 1'b0;
    logic        tp_frame  = 1'b0;
    int          k_s       = 0;
    int          n_chk     = 0;
    int          n_fail    = 0;

    logic [23:0] pdata_s, pdata_h;
    logic [10:0] x_s, y_s, x_h, y_h;
    logic        req_s, hs_s, vs_s, de_s, fs_s;
    logic        req_h, hs_h, vs_h, de_h, fs_h;
    logic [23:0] rgb_s, rgb_h;
    obs_t        obs_s, obs_h;

    assign obs_s = {hs_s, vs_s, de_s, fs_s, req_s, x_s, y_s, rgb_s};
    assign obs_h = {hs_h, vs_h, de_h, fs_h, req_h, x_h, y_h, rgb_h};

    always #5 pixel_clk = ~pixel_clk;

    video_timing_gen #(
        .H_SYNC(11'd4), .H_BACK(11'd6), .H_DISP(11'd16), .H_FRONT(11'd3),
        .V_SYNC(11'd2), .V_BACK(11'd3), .V_DISP(11'd6),  .V_FRONT(11'd2),
        .HS_POL(1'b0),  .VS_POL(1'b1)
    ) dut (
        .pixel_clk   (pixel_clk),
        .sys_rst_n   (rst_n),
`ifdef VIDEO_TPG_EN
        .tp_sel      (tp_sel),
`endif
        .pixel_data  (pdata_s),
        .pixel_xpos  (x_s),
        .pixel_ypos  (y_s),
        .data_req    (req_s),
        .video_hs    (hs_s),
        .video_vs    (vs_s),
        .video_de    (de_s),
        .video_rgb   (rgb_s),
        .frame_start (fs_s)
    );

    video_timing_gen dut_hd (
        .pixel_clk   (pixel_clk),
        .sys_rst_n   (rst_hd_n),
`ifdef VIDEO_TPG_EN
        .tp_sel      (tp_sel_hd),
`endif
        .pixel_data  (pdata_h),
        .pixel_xpos  (x_h),
        .pixel_ypos  (y_h),
        .data_req    (req_h),
        .video_hs    (hs_h),
        .video_vs    (vs_h),
        .video_de    (de_h),
        .video_rgb   (rgb_h),
        .frame_start (fs_h)
    );

    // Colour stages: register {2'b0, ypos, xpos} one clock after the request.
    always @(posedge pixel_clk) begin
        pdata_s <= {2'b00, y_s, x_s};
        pdata_h <= {2'b00, y_h, x_h};
    end

    // Clock edges since the small instance left reset; pattern mode taken at each frame origin.
    always @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            k_s      <= 0;
            tp_frame <= 1'b0;
        end else begin
            if (k_s % FR == 0) tp_frame <= tp_sel;
            k_s <= k_s + 1;
        end
    end

    function automatic logic [23:0] bar_ref(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected outputs after n clock edges out of reset: the flopped outputs show raster
    // position n-1, the request outputs show position n (positions taken modulo the frame).
    function automatic obs_t model(input int n, input logic tp);
        obs_t o;
        int   c, h, v;
        logic va;
        o    = '0;
        o.hs = ~HPOL;
        o.vs = ~VPOL;
        if (n > 0) begin
            c    = (n - 1) % FR;
            h    = c % HT;
            v    = c / HT;
            o.hs = (h < HS) ? HPOL : ~HPOL;
            o.vs = (v < VS) ? VPOL : ~VPOL;
            o.fs = (c == 0);
            o.de = (v >= VA) && (v < VA + VD) && (h >= HA) && (h < HA + HD);
            if (o.de) o.rgb = tp ? bar_ref((h - HA) / (HD / 8)) : {2'b00, 11'(v - VA), 11'(h - HA)};
        end
        c     = n % FR;
        h     = c % HT;
        v     = c / HT;
        va    = (v >= VA) && (v < VA + VD);
        o.req = va && (h >= HA - 1) && (h < HA + HD - 1);
        o.x   = o.req ? 11'(h - HA + 1) : 11'd0;
        o.y   = va ? 11'(v - VA) : 11'd0;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int c, input logic hs, input logic vs, input logic de,
                                input logic fs, input logic req, input int x, input int y,
                                input logic [23:0] rgb);
        vec_t r;
        r.cyc = c;
        r.exp = {hs, vs, de, fs, req, 11'(x), 11'(y), rgb};
        return r;
    endfunction

    // Per-cycle comparison of the small instance against the raster model.
    always @(negedge pixel_clk) begin
        if (mon_en) chk("cycle_model", 64'(obs_s), 64'(model(k_s, tp_frame)));
    end

    // Called at a negedge sample point: find the next frame_start, then count one whole frame.
    task automatic measure_frame(input logic tp, output int w);
        int de_n, rows, bad_lines, bad_rgb, vs_n, hs_n;
        logic [23:0] er;
        w = 0;
        while (fs_s !== 1'b1 && w < 2 * FR) begin
            @(negedge pixel_clk);
            w++;
        end
        chk("frame_start_found", 64'(w < 2 * FR), 64'd1);
        de_n = 0; rows = 0; bad_lines = 0; bad_rgb = 0; vs_n = 0; hs_n = 0;
        for (int i = 0; i < FR; i++) begin
            if (vs_s === VPOL) vs_n++;
            if (hs_s === HPOL) hs_n++;
            if (de_s === 1'b1) begin
                er = tp ? bar_ref(de_n / (HD / 8)) : {2'b00, 11'(rows), 11'(de_n)};
                if (rgb_s !== er) bad_rgb++;
                de_n++;
            end else if (rgb_s !== 24'd0) begin
                bad_rgb++;
            end
            if (i % HT == HT - 1) begin
                if (de_n > 0) begin
                    rows++;
                    if (de_n != HD) bad_lines++;
                end
                de_n = 0;
            end
            @(negedge pixel_clk);
        end
        chk("frame_period",  64'(fs_s), 64'd1);
        chk("active_lines",  64'(rows), 64'(VD));
        chk("de_per_line",   64'(bad_lines), 64'd0);
        chk("vs_width",      64'(vs_n), 64'(VS * HT));
        chk("hs_width",      64'(hs_n), 64'(HS * VT));
        chk("rgb_order",     64'(bad_rgb), 64'd0);
    endtask

    vec_t tbl [19];

    initial begin
        int cur, w;

        // 720p checkpoints: cycle = clock edges after reset release
        tbl[0]  = mk(0,     0, 0, 0, 0, 0, 0,    0, 24'h0);
        tbl[1]  = mk(1,     1, 1, 0, 1, 0, 0,    0, 24'h0);
        tbl[2]  = mk(2,     1, 1, 0, 0, 0, 0,    0, 24'h0);
        tbl[3]  = mk(40,    1, 1, 0, 0, 0, 0,    0, 24'h0);
        tbl[4]  = mk(41,    0, 1, 0, 0, 0, 0,    0, 24'h0);
        tbl[5]  = mk(1651,  1, 1, 0, 0, 0, 0,    0, 24'h0);
        tbl[6]  = mk(1690,  1, 1, 0, 0, 0, 0,    0, 24'h0);
        tbl[7]  = mk(1691,  0, 1, 0, 0, 0, 0,    0, 24'h0);
        tbl[8]  = mk(8250,  0, 1, 0, 0, 0, 0,    0, 24'h0);
        tbl[9]  = mk(8251,  1, 0, 0, 0, 0, 0,    0, 24'h0);
        tbl[10] = mk(39860, 0, 0, 0, 0, 0, 0,    0, 24'h0);
        tbl[11] = mk(41509, 0, 0, 0, 0, 1, 0,    0, 24'h0);
        tbl[12] = mk(49758, 0, 0, 0, 0, 0, 0,    5, 24'h0);
        tbl[13] = mk(49759, 0, 0, 0, 0, 1, 0,    5, 24'h0);
        tbl[14] = mk(49761, 0, 0, 1, 0, 1, 2,    5, 24'h002800);
        tbl[15] = mk(51038, 0, 0, 1, 0, 1, 1279, 5, 24'h002CFD);
        tbl[16] = mk(51039, 0, 0, 1, 0, 0, 0,    5, 24'h002CFE);
        tbl[17] = mk(51040, 0, 0, 1, 0, 0, 0,    5, 24'h002CFF);
        tbl[18] = mk(51041, 0, 0, 0, 0, 0, 0,    5, 24'h0);

        // 720p instance: reset state, then table walk
        repeat (3) @(posedge pixel_clk);
        #2;
        chk("hd_reset_state", 64'(obs_h), 64'(obs_t'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 24'd0})));
        rst_hd_n = 1'b1;
        #1;
        cur = 0;
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].cyc > cur) begin
                repeat (tbl[i].cyc - cur) @(posedge pixel_clk);
                cur = tbl[i].cyc;
                #2;
            end
            chk($sformatf("hd_vec%0d_cyc%0d", i, tbl[i].cyc), 64'(obs_h), 64'(tbl[i].exp));
        end
        rst_hd_n = 1'b0;

        // Small instance: reset state, release, two free-running frames
        @(posedge pixel_clk);
        #2;
        chk("sm_reset_state", 64'(obs_s), 64'(model(0, 1'b0)));
        mon_en = 1'b1;
        #($urandom_range(1, 3));
        rst_n = 1'b1;
        @(negedge pixel_clk);
        measure_frame(1'b0, w);
        chk("fs_after_release", 64'(w), 64'd1);
        measure_frame(1'b0, w);

        // Random mid-frame resets: outputs drop at once, a whole frame follows release
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(30, 2 * FR)) @(posedge pixel_clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk("async_reset_outputs", 64'(obs_s), 64'(model(0, 1'b0)));
            repeat ($urandom_range(1, 4)) @(posedge pixel_clk);
            #2;
            rst_n = 1'b1;
            @(negedge pixel_clk);
            measure_frame(1'b0, w);
            chk("fs_after_rerelease", 64'(w), 64'd1);
        end

`ifdef VIDEO_TPG_EN
        // Pattern selected mid-frame: current frame untouched, next frame all bars;
        // dropping tp_sel inside the bar frame leaves that frame intact.
        @(posedge pixel_clk);
        #2;
        tp_sel = 1'b1;
        @(negedge pixel_clk);
        measure_frame(1'b0, w);
        measure_frame(1'b1, w);
        tp_sel = 1'b0;
        measure_frame(1'b1, w);
        measure_frame(1'b0, w);
`endif

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: summary not reached, %0d of %0d comparisons failed so far", n_fail, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
